// File: rtl/piano_seq_pkg.sv
// Shared types and constants for the Piano command sequencer.
// No logic; no latency.
// No flow control; types only.
package piano_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_HOLD    = 3'd2,
        ST_GAP     = 3'd3,
        ST_SILENCE = 3'd4
    } seq_state_t;

    localparam logic [7:0] SILENCE_CMD = 8'h00;

    // Queue entry layout: command in the low byte, duration in ticks above it.
    localparam int CMD_LSB = 0;
    localparam int CMD_MSB = 7;
    localparam int DUR_LSB = 8;
    localparam int DUR_MSB = 15;
    localparam int ENTRY_W = 16;

endpackage

// File: rtl/piano_cmd_fifo.sv
// Synchronous FIFO of 16-bit command entries with occupancy count and clear.
// Push visible on head one cycle after the write edge; head is read combinationally.
// Push while full is accepted only with a same-cycle pop; clear beats push and pop.
module piano_cmd_fifo
    import piano_seq_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
)(
    input  logic                 iCpuClock,
    input  logic                 iCpuReset,
    input  logic                 push_vld,
    input  logic [ENTRY_W-1:0]   push_dat,
    input  logic                 pop_vld,
    input  logic                 clear,
    output logic [ENTRY_W-1:0]   head_dat,
    output logic [DEPTH_LOG2:0]  count,
    output logic                 full,
    output logic                 empty
);
    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam int                  CW        = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]       DEPTH_CNT = CW'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [ENTRY_W-1:0]    mem_q [DEPTH];
    logic [ENTRY_W-1:0]    mem_d [DEPTH];
    logic                  do_push;
    logic                  do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_CNT);
    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];
    assign do_pop   = pop_vld & ~empty & ~clear;
    assign do_push  = push_vld & (~full | do_pop) & ~clear;

    // Pointer/count/storage update; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            count_d = count_q + {{(CW-1){1'b0}}, do_push} - {{(CW-1){1'b0}}, do_pop};
        end
    end

    // Control registers with asynchronous reset.
    always_ff @(posedge iCpuClock or posedge iCpuReset) begin
        if (iCpuReset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset; occupancy tracking says what is valid.
    always_ff @(posedge iCpuClock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/piano_cmd_sequencer.sv
// Queues CPU (command, duration) writes and plays them to Piano, silencing at drain/flush; PIANO_SEQ_GAP_EN adds inter-note gaps.
// An entry written at edge k strobes Piano in the cycle after edge k+1; each note then holds dur*TICK_DIV cycles.
// No stall to the CPU: writes into a full queue without a same-cycle pop are dropped and flagged in oOverflow.
module piano_cmd_sequencer
    import piano_seq_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int TICK_DIV   = 23000
`ifdef PIANO_SEQ_GAP_EN
    ,
    parameter int GAP_TICKS  = 10
`endif
)(
    input  logic                 iCpuClock,
    input  logic                 iCpuReset,
    input  logic                 iSeqWrite,
    input  logic [15:0]          iSeqData,
    input  logic                 iFlush,
    input  logic                 iClearOverflow,
    output logic                 oPianoWrite,
    output logic [7:0]           oPianoData,
    output logic                 oBusy,
    output logic                 oEmpty,
    output logic                 oFull,
    output logic [DEPTH_LOG2:0]  oCount,
    output logic                 oOverflow
);
    localparam int                  PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]       PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]       PRESC_ONE = PW'(1);
    localparam logic [DEPTH_LOG2:0] CNT_ONE   = 1;
`ifdef PIANO_SEQ_GAP_EN
    localparam logic [7:0]          GAP_DUR   = 8'(GAP_TICKS);
`endif

    seq_state_t           state_q, state_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [7:0]           dur_q, dur_d;
    logic [7:0]           data_q, data_d;
    logic                 ovf_q, ovf_d;
`ifdef PIANO_SEQ_GAP_EN
    logic                 gap_first_q, gap_first_d;
`endif

    logic [ENTRY_W-1:0]   fifo_head;
    logic [DEPTH_LOG2:0]  fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 go_next;
    logic                 piano_wr;
    logic [7:0]           piano_dat;

    // A flush discards any same-cycle write outright (no overflow).
    assign fifo_push = iSeqWrite & ~iFlush;

    piano_cmd_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .iCpuClock (iCpuClock),
        .iCpuReset (iCpuReset),
        .push_vld  (fifo_push),
        .push_dat  (iSeqData),
        .pop_vld   (fifo_pop),
        .clear     (iFlush),
        .head_dat  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Sequencer next-state, tick counting, Piano strobe and overflow flag.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        dur_d     = dur_q;
        ovf_d     = ovf_q;
        fifo_pop  = 1'b0;
        go_next   = 1'b0;
        piano_wr  = 1'b0;
        piano_dat = data_q;
`ifdef PIANO_SEQ_GAP_EN
        gap_first_d = gap_first_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                piano_wr  = 1'b1;
                piano_dat = fifo_head[CMD_MSB:CMD_LSB];
                fifo_pop  = 1'b1;
                presc_d   = '0;
                dur_d     = fifo_head[DUR_MSB:DUR_LSB];
                if (fifo_head[DUR_MSB:DUR_LSB] == 8'd0) begin
                    // The head is leaving this cycle, so only entries behind it count.
                    if (fifo_count > CNT_ONE) begin
                        go_next = 1'b1;
                    end else begin
                        state_d = ST_SILENCE;
                    end
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    dur_d   = dur_q - 8'd1;
                    if (dur_q <= 8'd1) begin
                        if (!fifo_empty) begin
                            go_next = 1'b1;
                        end else begin
                            state_d = ST_SILENCE;
                        end
                    end
                end else begin
                    presc_d = presc_q + PRESC_ONE;
                end
            end
`ifdef PIANO_SEQ_GAP_EN
            ST_GAP: begin
                if (gap_first_q) begin
                    piano_wr    = 1'b1;
                    piano_dat   = SILENCE_CMD;
                    gap_first_d = 1'b0;
                    if (dur_q == 8'd0) begin
                        state_d = ST_ISSUE;
                    end
                end else if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    dur_d   = dur_q - 8'd1;
                    if (dur_q <= 8'd1) begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    presc_d = presc_q + PRESC_ONE;
                end
            end
`endif
            ST_SILENCE: begin
                piano_wr  = 1'b1;
                piano_dat = SILENCE_CMD;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Following note: straight to ISSUE, or through a silent gap when enabled.
        if (go_next) begin
`ifdef PIANO_SEQ_GAP_EN
            state_d     = ST_GAP;
            presc_d     = '0;
            dur_d       = GAP_DUR;
            gap_first_d = 1'b1;
`else
            state_d     = ST_ISSUE;
`endif
        end

        // Piano keeps seeing the last command it was given.
        data_d = piano_wr ? piano_dat : data_q;

        if (iFlush) begin
            state_d = ST_SILENCE;
            presc_d = '0;
            dur_d   = 8'd0;
            ovf_d   = 1'b0;
`ifdef PIANO_SEQ_GAP_EN
            gap_first_d = 1'b0;
`endif
        end else if (fifo_push && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end else if (iClearOverflow) begin
            ovf_d = 1'b0;
        end
    end

    // Sequencer registers; reset returns silently since Piano shares the reset.
    always_ff @(posedge iCpuClock or posedge iCpuReset) begin
        if (iCpuReset) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            dur_q   <= 8'd0;
            data_q  <= 8'h00;
            ovf_q   <= 1'b0;
`ifdef PIANO_SEQ_GAP_EN
            gap_first_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            dur_q   <= dur_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
`ifdef PIANO_SEQ_GAP_EN
            gap_first_q <= gap_first_d;
`endif
        end
    end

    assign oPianoWrite = piano_wr;
    assign oPianoData  = piano_dat;
    assign oBusy       = (state_q != ST_IDLE);
    assign oEmpty      = fifo_empty;
    assign oFull       = fifo_full;
    assign oCount      = fifo_count;
    assign oOverflow   = ovf_q;

endmodule

// File: tb/tb_piano_cmd_sequencer.sv
// Randomized and directed bench for piano_cmd_sequencer against a cycle-countdown reference model.
// Checks every DUT output each cycle plus strobe timing of the directed scenarios.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_piano_cmd_sequencer;

    localparam int TD    = 4;
    localparam int DL2   = 2;
    localparam int DEPTH = 1 << DL2;
`ifdef PIANO_SEQ_GAP_EN
    localparam int GT    = 2;
`endif

    logic        iCpuClock = 1'b0;
    logic        iCpuReset = 1'b1;
    logic        iSeqWrite = 1'b0;
    logic [15:0] iSeqData  = 16'h0;
    logic        iFlush    = 1'b0;
    logic        iClearOverflow = 1'b0;
    logic        oPianoWrite;
    logic [7:0]  oPianoData;
    logic        oBusy, oEmpty, oFull, oOverflow;
    logic [DL2:0] oCount;

    piano_cmd_sequencer #(
        .DEPTH_LOG2 (DL2),
        .TICK_DIV   (TD)
`ifdef PIANO_SEQ_GAP_EN
        ,
        .GAP_TICKS  (GT)
`endif
    ) dut (
        .iCpuClock      (iCpuClock),
        .iCpuReset      (iCpuReset),
        .iSeqWrite      (iSeqWrite),
        .iSeqData       (iSeqData),
        .iFlush         (iFlush),
        .iClearOverflow (iClearOverflow),
        .oPianoWrite    (oPianoWrite),
        .oPianoData     (oPianoData),
        .oBusy          (oBusy),
        .oEmpty         (oEmpty),
        .oFull          (oFull),
        .oCount         (oCount),
        .oOverflow      (oOverflow)
    );

    always #5 iCpuClock = ~iCpuClock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int sb_cyc[$];
    logic [7:0] sb_dat[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Phases of a note's life; durations are plain remaining-cycle counts.
    localparam int M_IDLE = 0, M_ISSUE = 1, M_HOLD = 2, M_GAP = 3, M_SIL = 4, M_NOTE = 5;
    int          m_phase;
    int          m_left;
    bit          m_gap_strobe;
    logic [15:0] m_q[$];
    logic [7:0]  m_last;
    bit          m_ovf;
    bit          e_wr;
    logic [7:0]  e_dat;

    task automatic model_reset();
        m_phase = M_IDLE; m_left = 0; m_gap_strobe = 0;
        m_q.delete(); m_last = 8'h00; m_ovf = 0;
    endtask

    task automatic model_outputs();
        logic [15:0] h;
        h = (m_q.size() > 0) ? m_q[0] : 16'h0;
        e_wr  = (m_phase == M_ISSUE) || (m_phase == M_SIL) || (m_phase == M_GAP && m_gap_strobe);
        e_dat = (m_phase == M_ISSUE) ? h[7:0] : (e_wr ? 8'h00 : m_last);
    endtask

    task automatic model_update(input bit wr, input logic [15:0] dat, input bit fl, input bit clr);
        int nxt;
        bit pop, accept;
        logic [15:0] h;
        model_outputs();
        if (e_wr) m_last = e_dat;
        if (fl) begin
            m_q.delete(); m_ovf = 0; m_phase = M_SIL; m_gap_strobe = 0;
            return;
        end
        pop = (m_phase == M_ISSUE);
        nxt = m_phase;
        case (m_phase)
            M_IDLE:  if (m_q.size() > 0) nxt = M_ISSUE;
            M_ISSUE: begin
                h = m_q[0];
                if (h[15:8] == 8'd0) nxt = (m_q.size() > 1) ? M_NOTE : M_SIL;
                else begin nxt = M_HOLD; m_left = int'(h[15:8]) * TD; end
            end
            M_HOLD: begin
                m_left--;
                if (m_left == 0) nxt = (m_q.size() > 0) ? M_NOTE : M_SIL;
            end
            M_GAP: begin
                m_gap_strobe = 0;
                m_left--;
                if (m_left == 0) nxt = M_ISSUE;
            end
            default: nxt = M_IDLE;
        endcase
        if (nxt == M_NOTE) begin
`ifdef PIANO_SEQ_GAP_EN
            nxt = M_GAP; m_left = GT * TD + 1; m_gap_strobe = 1;
`else
            nxt = M_ISSUE;
`endif
        end
        m_phase = nxt;
        accept = wr && ((m_q.size() < DEPTH) || pop);
        if (pop) void'(m_q.pop_front());
        if (accept) m_q.push_back(dat);
        if (wr && !accept) m_ovf = 1;
        else if (clr) m_ovf = 0;
    endtask

    // One clock: drive inputs, compare all outputs at the falling edge, advance model at the rising edge.
    task automatic cycle(input bit wr, input logic [15:0] dat, input bit fl, input bit clr);
        iSeqWrite = wr; iSeqData = dat; iFlush = fl; iClearOverflow = clr;
        @(negedge iCpuClock);
        model_outputs();
        check_val("piano_write", oPianoWrite, e_wr);
        check_val("piano_data",  oPianoData,  e_dat);
        check_val("busy",        oBusy,       m_phase != M_IDLE);
        check_val("count",       oCount,      m_q.size());
        check_val("empty",       oEmpty,      m_q.size() == 0);
        check_val("full",        oFull,       m_q.size() == DEPTH);
        check_val("overflow",    oOverflow,   m_ovf);
        if (oPianoWrite) begin
            sb_cyc.push_back(cyc);
            sb_dat.push_back(oPianoData);
        end
        @(posedge iCpuClock);
        model_update(wr, dat, fl, clr);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 16'h0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_empty"}, oEmpty, 1);
        check_val({tag, "_busy"},  oBusy, 0);
        check_val({tag, "_wr"},    oPianoWrite, 0);
        check_val({tag, "_data"},  oPianoData, 8'h00);
        check_val({tag, "_count"}, oCount, 0);
        check_val({tag, "_ovf"},   oOverflow, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        model_reset();
        repeat (3) @(posedge iCpuClock);
        #1 iCpuReset = 1'b0;
        check_reset_outputs("reset");

        // Single note: strobe two cycles after the write, silence 13 cycles later.
        sb_cyc.delete(); sb_dat.delete(); c0 = cyc;
        cycle(1, 16'h0311, 0, 0);
        idle(16);
        check_val("single_nstrobe", sb_dat.size(), 2);
        check_val("single_cyc0", sb_cyc[0] - c0, 2);
        check_val("single_dat0", sb_dat[0], 8'h11);
        check_val("single_cyc1", sb_cyc[1] - c0, 15);
        check_val("single_dat1", sb_dat[1], 8'h00);
        check_val("single_idle", oBusy, 0);

`ifdef PIANO_SEQ_GAP_EN
        sb_cyc.delete(); sb_dat.delete(); c0 = cyc;
        cycle(1, 16'h0111, 0, 0);
        cycle(1, 16'h0122, 0, 0);
        idle(24);
        check_val("gap_nstrobe", sb_dat.size(), 4);
        check_val("gap_dat0", sb_dat[0], 8'h11);
        check_val("gap_dat1", sb_dat[1], 8'h00);
        check_val("gap_dat2", sb_dat[2], 8'h22);
        check_val("gap_dat3", sb_dat[3], 8'h00);
        check_val("gap_cyc0", sb_cyc[0] - c0, 2);
        check_val("gap_cyc1", sb_cyc[1] - c0, 7);
        check_val("gap_cyc2", sb_cyc[2] - c0, 16);
        check_val("gap_cyc3", sb_cyc[3] - c0, 21);
`else
        sb_cyc.delete(); sb_dat.delete(); c0 = cyc;
        cycle(1, 16'h0111, 0, 0);
        cycle(1, 16'h0022, 0, 0);
        cycle(1, 16'h0133, 0, 0);
        idle(14);
        check_val("b2b_nstrobe", sb_dat.size(), 4);
        check_val("b2b_dat0", sb_dat[0], 8'h11);
        check_val("b2b_dat1", sb_dat[1], 8'h22);
        check_val("b2b_dat2", sb_dat[2], 8'h33);
        check_val("b2b_dat3", sb_dat[3], 8'h00);
        check_val("b2b_cyc0", sb_cyc[0] - c0, 2);
        check_val("b2b_cyc1", sb_cyc[1] - c0, 7);
        check_val("b2b_cyc2", sb_cyc[2] - c0, 8);
        check_val("b2b_cyc3", sb_cyc[3] - c0, 13);
`endif

        // Overflow: six writes while a long note starts; the 6th is dropped.
        cycle(1, 16'hFF11, 0, 0);
        cycle(1, 16'h0122, 0, 0);
        cycle(1, 16'h0133, 0, 0);
        cycle(1, 16'h0144, 0, 0);
        cycle(1, 16'h0155, 0, 0);
        cycle(1, 16'h0166, 0, 0);
        check_val("ovf_count", oCount, 4);
        check_val("ovf_full", oFull, 1);
        check_val("ovf_flag", oOverflow, 1);
        cycle(0, 16'h0, 0, 1);
        check_val("ovf_clear", oOverflow, 0);

        // Flush mid-note with a simultaneous write that must be discarded.
        sb_cyc.delete(); sb_dat.delete();
        cycle(1, 16'h0177, 1, 0);
        check_val("flush_count", oCount, 0);
        check_val("flush_busy", oBusy, 1);
        check_val("flush_wr", oPianoWrite, 1);
        check_val("flush_dat", oPianoData, 8'h00);
        idle(1);
        check_val("flush_idle", oBusy, 0);
        check_val("flush_empty", oEmpty, 1);

        // Flush while idle still produces one silence strobe.
        cycle(0, 16'h0, 1, 0);
        check_val("idle_flush_wr", oPianoWrite, 1);
        idle(2);

        // Reset in the middle of a note returns straight to reset values.
        cycle(1, 16'h0511, 0, 0);
        idle(6);
        #1 iCpuReset = 1'b1;
        #1 check_reset_outputs("midreset");
        model_reset();
        @(posedge iCpuClock);
        #1 iCpuReset = 1'b0;
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            bit          wr, fl, clr;
            logic [15:0] d;
            wr  = ($urandom_range(0, 99) < 35);
            fl  = ($urandom_range(0, 63) == 0);
            clr = ($urandom_range(0, 15) == 0);
            d   = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 255))};
            cycle(wr, d, fl, clr);
        end
        idle(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
